// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared register map, control bit indices and counter direction type
// Purpose: constants and types shared by the PWM top level, its timebase and software-facing code.
// Ports: none (package).
package pwm_pkg;

  localparam logic [6:0] ADDR_CTRL   = 7'h00;
  localparam logic [6:0] ADDR_PRESC  = 7'h01;
  localparam logic [6:0] ADDR_PERIOD = 7'h02;
  localparam logic [6:0] ADDR_OUT_EN = 7'h04;
  localparam logic [6:0] ADDR_PWM_EN = 7'h08;
  localparam logic [6:0] ADDR_POL    = 7'h0C;
  localparam logic [6:0] ADDR_DUTY   = 7'h10;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_CENTRE_BIT = 1;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, edge/centre up-down counter and period-end detection
// Purpose: shared time base for all PWM channels.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   run, centre : counter enable and centre-aligned mode select
//   presc       : prescaler terminal value (tick every presc+1 clocks)
//   period      : active period (counter top value)
//   cnt         : current counter value
//   period_end  : combinational, high on the tick that completes a period (only while running)
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               centre,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   cnt,
  output logic               period_end
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_t               dir_q, dir_d;
  logic               cnt_tick;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    cnt_tick    = 1'b0;
    period_end  = 1'b0;
    if (!run) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = UP;
    end else begin
      // >= rather than == so a PRESC lowered below the running count wraps at once
      cnt_tick    = (presc_cnt_q >= presc);
      presc_cnt_d = cnt_tick ? '0 : presc_cnt_q + 1'b1;
      if (cnt_tick) begin
        if (!centre) begin
          dir_d = UP;
          if (cnt_q >= period) begin
            cnt_d      = '0;
            period_end = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (dir_q == UP && cnt_q < period) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          // Landing on 0 closes the period; also covers period 0 and 1 where the
          // turn-around point already is (or is next to) zero.
          cnt_d      = '0;
          dir_d      = UP;
          period_end = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          dir_d = DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      dir_q       <= UP;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - N_CH-channel PWM with shared prescaled counter and double-buffered duty/period
// Purpose: register file, shadow/active duty and period, per-channel compare and output mux.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en       : register write strobe
//   wr_addr     : register address
//   wr_data     : register write data
//   out         : registered channel outputs
//   period_tick : registered 1-cycle pulse at the end of each counter period
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [6:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [N_CH-1:0]  out,
  output logic             period_tick
);

  localparam int N_BYTES = N_CH / 8;

  logic                           run_q, run_d;
  logic                           centre_q, centre_d;
  logic [PRESC_W-1:0]             presc_q, presc_d;
  logic [CNT_W-1:0]               period_sh_q, period_sh_d;
  logic [CNT_W-1:0]               period_act_q, period_act_d;
  logic [N_CH-1:0]                out_en_q, out_en_d;
  logic [N_CH-1:0]                pwm_en_q, pwm_en_d;
  logic [N_CH-1:0]                pol_q, pol_d;
  logic [N_CH-1:0][CNT_W-1:0]     duty_sh_q, duty_sh_d;
  logic [N_CH-1:0][CNT_W-1:0]     duty_act_q, duty_act_d;
  logic [N_CH-1:0]                out_q, out_d;
  logic                           period_tick_q, period_tick_d;

  logic [CNT_W-1:0]               cnt;
  logic                           period_end;
  logic                           load_act;
  logic [N_CH-1:0]                pwm_raw;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_q),
    .centre     (centre_q),
    .presc      (presc_q),
    .period     (period_act_q),
    .cnt        (cnt),
    .period_end (period_end)
  );

  // Register writes. Only shadows are written here; active copies follow below.
  always_comb begin
    run_d       = run_q;
    centre_d    = centre_q;
    presc_d     = presc_q;
    period_sh_d = period_sh_q;
    out_en_d    = out_en_q;
    pwm_en_d    = pwm_en_q;
    pol_d       = pol_q;
    duty_sh_d   = duty_sh_q;
    if (wr_en) begin
      if (wr_addr == ADDR_CTRL) begin
        run_d    = wr_data[CTRL_RUN_BIT];
        centre_d = wr_data[CTRL_CENTRE_BIT];
      end
      if (wr_addr == ADDR_PRESC)  presc_d     = wr_data[PRESC_W-1:0];
      if (wr_addr == ADDR_PERIOD) period_sh_d = wr_data;
      for (int k = 0; k < N_BYTES; k++) begin
        if (wr_addr == ADDR_OUT_EN + 7'(k)) out_en_d[k*8 +: 8] = wr_data[7:0];
        if (wr_addr == ADDR_PWM_EN + 7'(k)) pwm_en_d[k*8 +: 8] = wr_data[7:0];
        if (wr_addr == ADDR_POL + 7'(k))    pol_d[k*8 +: 8]    = wr_data[7:0];
      end
      for (int c = 0; c < N_CH; c++) begin
        if (wr_addr == ADDR_DUTY + 7'(c)) duty_sh_d[c] = wr_data;
      end
    end
  end

  // Active copies take the pre-write shadow, so a write landing on the period-end
  // edge waits for the following period.
  assign load_act = !run_q || period_end;

  always_comb begin
    period_act_d = load_act ? period_sh_q : period_act_q;
    duty_act_d   = load_act ? duty_sh_q : duty_act_q;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign pwm_raw[c] = run_q && (cnt < duty_act_q[c]);
    assign out_d[c]   = !out_en_q[c] ? 1'b0 :
                        !pwm_en_q[c] ? ~pol_q[c] :
                                       (pwm_raw[c] ^ pol_q[c]);
  end

  assign period_tick_d = period_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      centre_q      <= 1'b0;
      presc_q       <= '0;
      period_sh_q   <= '0;
      period_act_q  <= '0;
      out_en_q      <= '0;
      pwm_en_q      <= '0;
      pol_q         <= '0;
      duty_sh_q     <= '0;
      duty_act_q    <= '0;
      out_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      centre_q      <= centre_d;
      presc_q       <= presc_d;
      period_sh_q   <= period_sh_d;
      period_act_q  <= period_act_d;
      out_en_q      <= out_en_d;
      pwm_en_q      <= pwm_en_d;
      pol_q         <= pol_d;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      out_q         <= out_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign out         = out_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - self-checking bench for pwm_multichannel against a period-position model
module tb_pwm_multichannel;

  localparam int N_CH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [6:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [N_CH-1:0] out;
  logic            period_tick;

  always #5 clk = ~clk;

  pwm_multichannel #(.N_CH(N_CH), .CNT_W(8), .PRESC_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out         (out),
    .period_tick (period_tick)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the counter is tracked as a position inside the period (0..len-1),
  // and the counter value is derived from that position.
  bit              m_run, m_centre;
  int              m_presc, m_period_sh, m_period_act, m_div, m_pos;
  bit [N_CH-1:0]   m_oe, m_pe, m_pol;
  int              m_duty_sh[N_CH];
  int              m_duty_act[N_CH];
  logic [N_CH-1:0] exp_out;
  logic            exp_tick;
  int              mv_cnt, mv_idx;
  bit              mv_tick, mv_pend;

  function automatic int per_len();
    if (m_centre) return (m_period_act == 0) ? 1 : 2 * m_period_act;
    return m_period_act + 1;
  endfunction

  function automatic int cnt_at(input int p);
    if (!m_centre || p <= m_period_act) return p;
    return 2 * m_period_act - p;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_centre = 0; m_presc = 0; m_period_sh = 0; m_period_act = 0;
      m_div = 0; m_pos = 0; m_oe = '0; m_pe = '0; m_pol = '0;
      for (int c = 0; c < N_CH; c++) begin m_duty_sh[c] = 0; m_duty_act[c] = 0; end
      exp_out = '0; exp_tick = 1'b0;
    end else begin
      mv_cnt = cnt_at(m_pos);
      for (int c = 0; c < N_CH; c++)
        exp_out[c] = !m_oe[c] ? 1'b0 : !m_pe[c] ? !m_pol[c]
                   : ((m_run && (mv_cnt < m_duty_act[c])) ^ m_pol[c]);
      mv_tick  = m_run && (m_div == m_presc);
      mv_pend  = mv_tick && (m_pos == per_len() - 1);
      exp_tick = mv_pend;
      if (!m_run) begin m_div = 0; m_pos = 0; end
      else if (mv_tick) begin m_div = 0; m_pos = mv_pend ? 0 : m_pos + 1; end
      else m_div++;
      if (!m_run || mv_pend) begin
        m_period_act = m_period_sh;
        for (int c = 0; c < N_CH; c++) m_duty_act[c] = m_duty_sh[c];
      end
      if (wr_en) begin
        mv_idx = int'(wr_addr);
        if (mv_idx == 0) begin m_run = wr_data[0]; m_centre = wr_data[1]; end
        else if (mv_idx == 1) m_presc = wr_data;
        else if (mv_idx == 2) m_period_sh = wr_data;
        else if (mv_idx >= 4 && mv_idx < 4 + N_CH / 8) m_oe[(mv_idx - 4) * 8 +: 8] = wr_data;
        else if (mv_idx >= 8 && mv_idx < 8 + N_CH / 8) m_pe[(mv_idx - 8) * 8 +: 8] = wr_data;
        else if (mv_idx >= 12 && mv_idx < 12 + N_CH / 8) m_pol[(mv_idx - 12) * 8 +: 8] = wr_data;
        else if (mv_idx >= 16 && mv_idx < 16 + N_CH) m_duty_sh[mv_idx - 16] = wr_data;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_vs_model", 64'(out), 64'(exp_out));
      check("tick_vs_model", 64'(period_tick), 64'(exp_tick));
    end
  end

  // Measurements of observed behaviour, for the literal expectations.
  int cyc = 0, highs0 = 0, run_len = 0;
  int tick_q[$];
  int widths[$];

  task automatic tick1();
    @(negedge clk);
    cyc++;
    if (period_tick === 1'b1) tick_q.push_back(cyc);
    if (out[0] === 1'b1) begin highs0++; run_len++; end
    else if (run_len > 0) begin widths.push_back(run_len); run_len = 0; end
  endtask

  task automatic cycles(input int n);
    repeat (n) tick1();
  endtask

  task automatic clear_meas();
    highs0 = 0; run_len = 0; tick_q.delete(); widths.delete();
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    tick1();
    wr_en = 1'b0;
  endtask

  function automatic int spacing();
    return (tick_q.size() >= 2) ? tick_q[1] - tick_q[0] : -1;
  endfunction

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick1();
    chk_en = 1;
    cycles(2);
    check("reset_out", 64'(out), 64'd0);
    check("reset_tick", 64'(period_tick), 64'd0);
    rst_n = 1'b1;

    // Edge mode, period 10 clocks, duty 3; channel 15 also active
    wr(7'h02, 8'd9);
    wr(7'h01, 8'd0);
    wr(7'h04, 8'h01);
    wr(7'h08, 8'h01);
    wr(7'h05, 8'h80);
    wr(7'h09, 8'h80);
    wr(7'h10, 8'd3);
    wr(7'h1F, 8'd5);
    wr(7'h00, 8'h01);
    cycles(5);
    clear_meas();
    cycles(30);
    check("edge_highs_30", 64'(highs0), 64'd9);
    check("edge_ticks_30", 64'(tick_q.size()), 64'd3);
    check("edge_tick_spacing", 64'(spacing()), 64'd10);

    // Centre mode: 0..9 then 8..1 -> 18 clocks, cnt<3 on 0,1,2,2,1
    wr(7'h00, 8'h00);
    wr(7'h00, 8'h03);
    cycles(3);
    clear_meas();
    cycles(36);
    check("centre_highs_36", 64'(highs0), 64'd10);
    check("centre_tick_spacing", 64'(spacing()), 64'd18);

    // Duty change mid-period: finished pulse 3, next pulse 7, no runt
    wr(7'h00, 8'h00);
    wr(7'h00, 8'h01);
    clear_meas();
    cycles(4);
    wr(7'h10, 8'd7);
    cycles(25);
    check("dbuf_pulse_count", 64'(widths.size() >= 2), 64'd1);
    check("dbuf_first_width", 64'((widths.size() >= 1) ? widths[0] : -1), 64'd3);
    check("dbuf_second_width", 64'((widths.size() >= 2) ? widths[1] : -1), 64'd7);

    // Duty extremes and polarity
    wr(7'h10, 8'd0);
    cycles(12); clear_meas(); cycles(20);
    check("duty0_highs", 64'(highs0), 64'd0);
    wr(7'h10, 8'd10);
    cycles(12); clear_meas(); cycles(20);
    check("duty_over_highs", 64'(highs0), 64'd20);
    wr(7'h0C, 8'h01);
    cycles(2); clear_meas(); cycles(20);
    check("duty_over_pol_highs", 64'(highs0), 64'd0);
    wr(7'h10, 8'd0);
    cycles(12); clear_meas(); cycles(20);
    check("duty0_pol_highs", 64'(highs0), 64'd20);
    wr(7'h0C, 8'h00);
    wr(7'h0D, 8'h80);

    // Static output on channel 1, output-enable latency, unmapped write
    wr(7'h04, 8'h03);
    tick1();
    check("ch1_static_high", 64'(out[1]), 64'd1);
    wr(7'h04, 8'h01);
    check("ch1_oe_clear_latency", 64'(out[1]), 64'd1);
    tick1();
    check("ch1_oe_cleared", 64'(out[1]), 64'd0);
    wr(7'h7F, 8'hFF);
    cycles(3);
    check("unmapped_ch1", 64'(out[1]), 64'd0);

    // Prescaler 3: counter advances every 4 clocks, period 40 clocks
    wr(7'h00, 8'h00);
    wr(7'h10, 8'd3);
    wr(7'h01, 8'd3);
    wr(7'h00, 8'h01);
    clear_meas();
    cycles(85);
    check("presc_tick_spacing", 64'(spacing()), 64'd40);
    check("presc_highs", 64'(highs0 >= 24 && highs0 <= 36), 64'd1);

    // Reset mid-period
    cycles(7);
    rst_n = 1'b0;
    tick1();
    check("midreset_out", 64'(out), 64'd0);
    check("midreset_tick", 64'(period_tick), 64'd0);
    rst_n = 1'b1;
    cycles(5);
    check("after_reset_out", 64'(out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
